dmem_unit: RTL and testbench
============================

// Module: dmem_unit
// PURPOSE
//  Parametrised RV32 data memory for the mem_unit stage. Word RAM with a valid/ready request port.
//  Byte/half/word loads and stores follow funct3, with sign/zero extension and byte-lane write masking.
//  Read latency is configurable. After reset a hardware sweep clears the array. Misaligned or
//  out-of-range accesses return resp_err.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words; power of two, >= 4
//  READ_LAT     1     clock edges from request accept to load response; 1..4
// PORTS
//  clk         in   1   single clock, rising edge
//  reset_n     in   1   asynchronous, active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   request accepted when req_valid & req_ready at the rising edge
//  req_we      in   1   1 = store, 0 = load
//  req_funct3  in   3   RV32 width: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  resp_valid  out  1   one-cycle response pulse (loads and stores)
//  resp_rdata  out  32  extended load data; 0 for stores and errors
//  resp_err    out  1   qualifies resp_valid: access rejected
//  init_busy   out  1   clear sweep in progress
// BEHAVIOUR
//  Reset (async): state=CLEAR, clr_idx=0, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0,
//   init_busy=1. The RAM array itself is never cleared by the reset.
//  CLEAR: writes 0 to word clr_idx each cycle and increments clr_idx.
//   After word DEPTH_WORDS-1 is written: state becomes IDLE and init_busy drops.
//   The sweep takes exactly DEPTH_WORDS cycles. Requests are ignored while the sweep runs.
//  IDLE: req_ready=1.
//   - Store accept: the masked write commits at the accepting edge.
//     resp_valid comes in the next cycle. State stays IDLE, so back-to-back stores run at 1 per cycle.
//   - Load accept: go to WAIT with cnt=READ_LAT-1. The word is captured at the accepting edge.
//  WAIT: req_ready=0. cnt decrements each cycle.
//   At cnt==0 the next edge returns to IDLE and registers resp_valid, resp_rdata and resp_err.
//   So resp_valid rises exactly READ_LAT edges after accept, and req_ready=1 in that same cycle.
//  Reset mid-WAIT or mid-CLEAR: drop everything and restart CLEAR from index 0.
//  Word index = req_addr[log2(DEPTH_WORDS)+1:2]. Byte lane = req_addr[1:0].
//  Store masks: SB -> 4'b0001 << a[1:0]. SH -> 4'b0011 << a[1:0]. SW -> 4'b1111.
//   Data is replicated into the selected lanes.
//  Load extract: select lane(s) by a[1:0].
//   LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW passes the word through.
//  Error when req_addr >= 4*DEPTH_WORDS or funct3 is illegal (011, 110, 111; also 100/101 with we=1).
//   On error: no write, resp_err=1, resp_rdata=0. Latency is the same as for a legal access of that kind.
//  Read-after-write: a load accepted the cycle after a store to the same word returns the new data.
// CONFIGURATION
//  DMEM_MISALIGN_TRAP_EN
//   defined:   halfword with a[0]=1, or word with a[1:0]!=0, gives resp_err=1 and no write.
//   undefined: low address bits are forced aligned (half: a[0]=0; word: a[1:0]=0)
//              and the access proceeds without error.
// STRUCTURE
//  dmem_pkg:
//   - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU
//   - state encoding S_CLEAR, S_IDLE, S_WAIT
//   - function byte_mask(funct3, a[1:0])
//  Sub-module dmem_load_align (combinational): word, a[1:0], funct3 -> extended rdata.
//  Top holds the FSM, counters, mem array and response registers.
// TESTING
//  1. Reset, DEPTH_WORDS=16: init_busy high for exactly 16 cycles; req_ready low until then;
//     then LW 0x3C returns 0.
//  2. SW 0x10=0xDEADBEEF, then LW 0x10: resp_valid exactly READ_LAT edges after accept
//     (check READ_LAT=1 and 3); rdata=0xDEADBEEF.
//  3. After test 2, SB 0x11=0x7F then SH 0x12=0x8001:
//     LW 0x10 -> 0x80017FEF; LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080;
//     LH 0x12 -> 0xFFFF8001; LHU 0x12 -> 0x00008001.
//  4. Out of range: SW to 0x40 with DEPTH_WORDS=16 -> resp_err=1 and the array is unchanged.
//     Also funct3=011 -> resp_err=1.
//  5. SH 0x21 and LW 0x22:
//     with DMEM_MISALIGN_TRAP_EN -> resp_err=1 and no write;
//     without it -> the write lands at 0x20 and the load reads 0x20.
//  6. Assert reset_n low during WAIT and during CLEAR:
//     resp_valid=0 at once; the full sweep restarts; no stale response appears after release.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the RV32 data memory: funct3 codes, FSM states
// and the store byte-lane mask helper.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  function automatic logic [3:0] byte_mask(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (f3)
      F3_B:    m = 4'b0001 << a;
      F3_H:    m = 4'b0011 << a;
      F3_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load lane select and sign/zero extension.
// Ports: word (raw RAM word), a (byte lane), funct3 (width) -> rdata.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  a,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b     = word[{a, 3'b000} +: 8];
    h     = a[1] ? word[31:16] : word[15:0];
    rdata = word;
    unique case (funct3)
      F3_B:    rdata = {{24{b[7]}}, b};
      F3_BU:   rdata = {24'h0, b};
      F3_H:    rdata = {{16{h[15]}}, h};
      F3_HU:   rdata = {16'h0, h};
      default: rdata = word;
    endcase
  end

endmodule

// File: rtl/dmem_unit.sv
// RV32 data memory for the mem_unit stage: valid/ready port, byte/half/word
// access, post-reset clear sweep, configurable load latency.
// Ports: clk, reset_n, req_* (request), resp_* (response pulse), init_busy.
// Option: define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses.
module dmem_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        init_busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST = AW'(DEPTH_WORDS - 1);
  localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

  logic [31:0] mem [DEPTH_WORDS];

  state_e        state_q, state_d;
  logic [AW-1:0] clr_q, clr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   ld_word_q, ld_word_d;
  logic [1:0]    ld_a_q, ld_a_d;
  logic [2:0]    ld_f3_q, ld_f3_d;
  logic          ld_err_q, ld_err_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;

  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic          f3_bad, range_bad, mis_bad, req_err;
  logic [31:0]   wdata_rep;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_idx;
  logic [31:0]   mem_wdata;
  logic [31:0]   ld_ext;

  assign widx      = req_addr[AW+1:2];
  assign range_bad = |req_addr[31:AW+2];
  assign req_ready = (state_q == S_IDLE);
  assign init_busy = (state_q == S_CLEAR);

  always_comb begin
    f3_bad = 1'b1;
    unique case (req_funct3)
      F3_B, F3_H, F3_W: f3_bad = 1'b0;
      F3_BU, F3_HU:     f3_bad = req_we;
      default:          f3_bad = 1'b1;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    lane    = req_addr[1:0];
    mis_bad = (req_funct3[1:0] == 2'b01 && req_addr[0])
            || (req_funct3 == F3_W && req_addr[1:0] != 2'b00);
  end
`else
  // Misaligned halves/words silently snap down to their natural boundary.
  always_comb begin
    mis_bad = 1'b0;
    lane    = req_addr[1:0];
    if (req_funct3[1:0] == 2'b01) lane[0] = 1'b0;
    else if (req_funct3 == F3_W) lane = 2'b00;
  end
`endif

  assign req_err = f3_bad | range_bad | mis_bad;

  always_comb begin
    unique case (req_funct3[1:0])
      2'b00:   wdata_rep = {4{req_wdata[7:0]}};
      2'b01:   wdata_rep = {2{req_wdata[15:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  dmem_load_align u_align (
    .word   (ld_word_q),
    .a      (ld_a_q),
    .funct3 (ld_f3_q),
    .rdata  (ld_ext)
  );

  always_comb begin
    state_d      = state_q;
    clr_d        = clr_q;
    cnt_d        = cnt_q;
    ld_word_d    = ld_word_q;
    ld_a_d       = ld_a_q;
    ld_f3_d      = ld_f3_q;
    ld_err_d     = ld_err_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;
    mem_we       = 1'b0;
    mem_be       = 4'b0000;
    mem_idx      = widx;
    mem_wdata    = wdata_rep;
    unique case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_be    = 4'b1111;
        mem_idx   = clr_q;
        mem_wdata = 32'h0;
        clr_d     = clr_q + 1'b1;
        if (clr_q == LAST) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (req_valid) begin
          if (req_we) begin
            mem_we       = !req_err;
            mem_be       = byte_mask(req_funct3, lane);
            resp_valid_d = 1'b1;
            resp_err_d   = req_err;
          end else begin
            state_d   = S_WAIT;
            cnt_d     = LAT_M1;
            ld_word_d = mem[widx];
            ld_a_d    = lane;
            ld_f3_d   = req_funct3;
            ld_err_d  = req_err;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b1;
          resp_err_d   = ld_err_q;
          resp_rdata_d = ld_err_q ? 32'h0 : ld_ext;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_CLEAR;
      clr_q        <= '0;
      cnt_q        <= 2'd0;
      ld_word_q    <= 32'h0;
      ld_a_q       <= 2'b00;
      ld_f3_q      <= 3'b000;
      ld_err_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      clr_q        <= clr_d;
      cnt_q        <= cnt_d;
      ld_word_q    <= ld_word_d;
      ld_a_q       <= ld_a_d;
      ld_f3_q      <= ld_f3_d;
      ld_err_q     <= ld_err_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_unit.sv
// Bench for dmem_unit: two instances (READ_LAT 1 and 3) driven in lockstep
// and checked against a byte-addressed reference memory.
module tb_dmem_unit;

  localparam int DW = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [1:0]  req_ready, resp_valid, resp_err, init_busy;
  logic [31:0] rdata0, rdata1;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] ref_mem [4*DW];

  always #5 clk = ~clk;

  dmem_unit #(.DEPTH_WORDS(DW), .READ_LAT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid),
    .req_ready(req_ready[0]), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid[0]),
    .resp_rdata(rdata0), .resp_err(resp_err[0]),
    .init_busy(init_busy[0])
  );

  dmem_unit #(.DEPTH_WORDS(DW), .READ_LAT(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid),
    .req_ready(req_ready[1]), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid[1]),
    .resp_rdata(rdata1), .resp_err(resp_err[1]),
    .init_busy(init_busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 4*DW; i++) ref_mem[i] = 8'h00;
  endtask

  // Reference: memory as a flat byte array, RV32 width rules.
  task automatic model(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic err, output logic [31:0] rd);
    int sz, base;
    bit uns, bad;
    logic [63:0] v;
    sz = 4; uns = 0; bad = 0; rd = 32'h0;
    case (f3)
      3'd0: sz = 1;
      3'd1: sz = 2;
      3'd2: sz = 4;
      3'd4: begin sz = 1; uns = 1; bad = we; end
      3'd5: begin sz = 2; uns = 1; bad = we; end
      default: bad = 1;
    endcase
    if (a >= 32'(4*DW)) bad = 1;
    base = bad ? 0 : int'(a);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (base % sz != 0) bad = 1;
`else
    base = base - base % sz;
`endif
    err = bad;
    if (bad) return;
    if (we) begin
      for (int i = 0; i < sz; i++) ref_mem[base+i] = wd[8*i +: 8];
    end else begin
      v = 64'h0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[base+i];
      if (!uns && sz < 4 && v[8*sz-1]) v = v | ~((64'd1 << (8*sz)) - 1);
      rd = v[31:0];
    end
  endtask

  task automatic xfer(input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input string tag, output logic [31:0] got);
    logic e_err;
    logic [31:0] e_rd;
    int lat [2];
    logic [31:0] rd_s [2];
    logic er_s [2];
    int w;
    model(we, f3, a, wd, e_err, e_rd);
    lat = '{-1, -1};
    rd_s = '{32'h0, 32'h0};
    er_s = '{1'b0, 1'b0};
    w = 0;
    @(negedge clk);
    while (req_ready != 2'b11 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " ready"}, 32'(req_ready), 32'h3);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int t = 0; t <= 8; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      for (int k = 0; k < 2; k++) begin
        if (resp_valid[k] && lat[k] < 0) begin
          lat[k] = t;
          rd_s[k] = (k == 0) ? rdata0 : rdata1;
          er_s[k] = resp_err[k];
        end
      end
      if (lat[0] >= 0 && lat[1] >= 0) break;
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s lat%0d", tag, k), 32'(lat[k]),
          we ? 32'd0 : ((k == 0) ? 32'd1 : 32'd3));
      chk($sformatf("%s err%0d", tag, k), 32'(er_s[k]), 32'(e_err));
      chk($sformatf("%s rdata%0d", tag, k), rd_s[k], e_rd);
    end
    got = rd_s[1];
  endtask

  // Call right after reset_n is released on a falling edge.
  task automatic sweep(input string tag);
    int n [2];
    bit rdy_bad, stale;
    n = '{0, 0};
    rdy_bad = 0; stale = 0;
    for (int t = 1; t <= 100; t++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (n[k] == 0 && !init_busy[k]) n[k] = t;
        if (init_busy[k] && req_ready[k]) rdy_bad = 1;
      end
      if (resp_valid != 2'b00) stale = 1;
      if (n[0] != 0 && n[1] != 0) break;
    end
    chk({tag, " busy cycles0"}, 32'(n[0]), 32'(DW));
    chk({tag, " busy cycles1"}, 32'(n[1]), 32'(DW));
    chk({tag, " ready while busy"}, 32'(rdy_bad), 32'd0);
    chk({tag, " stale resp"}, 32'(stale), 32'd0);
    ref_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g;
    logic [2:0] f3;
    logic [31:0] a;
    ref_clear();
    #1 reset_n = 1'b0;
    #1;
    chk("rst resp_valid", 32'(resp_valid), 32'h0);
    chk("rst req_ready", 32'(req_ready), 32'h0);
    chk("rst init_busy", 32'(init_busy), 32'h3);
    chk("rst rdata", rdata0 | rdata1, 32'h0);
    chk("rst err", 32'(resp_err), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    sweep("t1");
    xfer(0, 3'd2, 32'h3C, 32'h0, "t1 lw3c", g);
    chk("t1 lw3c val", g, 32'h0);

    xfer(1, 3'd2, 32'h10, 32'hDEADBEEF, "t2 sw", g);
    xfer(0, 3'd2, 32'h10, 32'h0, "t2 lw", g);
    chk("t2 lw val", g, 32'hDEADBEEF);

    xfer(1, 3'd0, 32'h11, 32'h7F, "t3 sb", g);
    xfer(1, 3'd1, 32'h12, 32'h8001, "t3 sh", g);
    xfer(0, 3'd2, 32'h10, 32'h0, "t3 lw", g);
    chk("t3 lw val", g, 32'h80017FEF);
    xfer(0, 3'd0, 32'h13, 32'h0, "t3 lb", g);
    chk("t3 lb val", g, 32'hFFFFFF80);
    xfer(0, 3'd4, 32'h13, 32'h0, "t3 lbu", g);
    chk("t3 lbu val", g, 32'h00000080);
    xfer(0, 3'd1, 32'h12, 32'h0, "t3 lh", g);
    chk("t3 lh val", g, 32'hFFFF8001);
    xfer(0, 3'd5, 32'h12, 32'h0, "t3 lhu", g);
    chk("t3 lhu val", g, 32'h00008001);

    xfer(1, 3'd2, 32'h40, 32'h12345678, "t4 sw oor", g);
    xfer(0, 3'd2, 32'h00, 32'h0, "t4 lw0", g);
    chk("t4 lw0 val", g, 32'h0);
    xfer(0, 3'd3, 32'h10, 32'h0, "t4 f3 011", g);
    xfer(1, 3'd4, 32'h10, 32'hFF, "t4 sbu", g);

    xfer(1, 3'd1, 32'h21, 32'h0000A5A5, "t5 sh", g);
    xfer(0, 3'd2, 32'h22, 32'h0, "t5 lw", g);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("t5 lw val", g, 32'h0);
`else
    chk("t5 lw val", g, 32'h0000A5A5);
`endif
    xfer(0, 3'd2, 32'h20, 32'h0, "t5 lw20", g);

    // Back-to-back stores followed immediately by a read-after-write.
    xfer(1, 3'd2, 32'h30, 32'h11223344, "raw sw", g);
    xfer(1, 3'd0, 32'h31, 32'hAA, "raw sb", g);
    xfer(0, 3'd2, 32'h30, 32'h0, "raw lw", g);
    chk("raw lw val", g, 32'h1122AA44);

    for (int i = 0; i < 80; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = 32'($urandom_range(0, 4*DW + 15));
      xfer(1'($urandom_range(0, 1)), f3, a, $urandom,
           $sformatf("rnd%0d", i), g);
    end

    @(negedge clk);
    while (req_ready != 2'b11) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2;
    req_addr = 32'h10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("t6 wait resp_valid", 32'(resp_valid), 32'h0);
    chk("t6 wait busy", 32'(init_busy), 32'h3);
    chk("t6 wait ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    sweep("t6 wait");

    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("t6 clr resp_valid", 32'(resp_valid), 32'h0);
    chk("t6 clr busy", 32'(init_busy), 32'h3);
    @(negedge clk);
    reset_n = 1'b1;
    sweep("t6 clr");
    xfer(0, 3'd2, 32'h10, 32'h0, "t6 lw", g);
    chk("t6 lw val", g, 32'h0);
    for (int i = 0; i < 20; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = 32'($urandom_range(0, 4*DW + 15));
      xfer(1'($urandom_range(0, 1)), f3, a, $urandom,
           $sformatf("post%0d", i), g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
